gated_cycle_counter: RTL and testbench



---
 rtl/gated_cycle_counter_pkg.sv | 9 +
 rtl/gated_cycle_counter_if.sv | 39 +++
 rtl/gated_cycle_counter_core.sv | 69 ++++++
 rtl/gcc_flop_chain.sv | 31 +++
 rtl/gated_cycle_counter.sv | 47 ++++
 tb/tb_gated_cycle_counter.sv | 222 ++++++++++++++++++++++
 6 files changed

// File: rtl/gated_cycle_counter_pkg.sv
// Shared defaults for the gated cycle counter.
// Counter width and control-pipeline depths.
package gated_cycle_counter_pkg;

  localparam int default_width_c = 32;
  localparam int default_sync_c  = 2;
  localparam int default_delay_c = 3;

endpackage

// File: rtl/gated_cycle_counter_if.sv
// Control/status bundle between the counter wrapper and its core.
// GATED_CYCLE_COUNTER_SNAPSHOT_EN adds the snapshot request and capture.
interface gated_cycle_counter_if
  import gated_cycle_counter_pkg::*;
#(
  parameter int width_p = default_width_c
) ();

  logic               start;
  logic               clear;
  logic [width_p-1:0] ctr;
  logic               running;
  logic               wrap;
`ifdef GATED_CYCLE_COUNTER_SNAPSHOT_EN
  logic               snapshot;
  logic [width_p-1:0] snap;

  modport master (
    output start, clear, snapshot,
    input  ctr, running, wrap, snap
  );

  modport slave (
    input  start, clear, snapshot,
    output ctr, running, wrap, snap
  );
`else
  modport master (
    output start, clear,
    input  ctr, running, wrap
  );

  modport slave (
    input  start, clear,
    output ctr, running, wrap
  );
`endif

endinterface

// File: rtl/gated_cycle_counter_core.sv
// Counter core: synchronizer, delay chain and gated modular counter.
// GATED_CYCLE_COUNTER_SNAPSHOT_EN adds the snapshot capture register.
module gated_cycle_counter_core
  import gated_cycle_counter_pkg::*;
#(
  parameter int width_p       = default_width_c,
  parameter int sync_stages_p = default_sync_c,
  parameter int delay_p       = default_delay_c
) (
  input logic             clk_i,
  input logic             reset_n_i,
  gated_cycle_counter_if.slave bus
);

  localparam logic [width_p-1:0] one_c = width_p'(1);

  logic               synced;
  logic               running;
  logic [width_p-1:0] ctr_r;
  logic               wrap_r;

  (* ASYNC_REG = "TRUE" *)
  gcc_flop_chain #(.depth(sync_stages_p)) u_sync (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .d_i       (bus.start),
    .q_o       (synced)
  );

  gcc_flop_chain #(.depth(delay_p)) u_delay (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .d_i       (synced),
    .q_o       (running)
  );

  // Stop and clear both zero the count and suppress the wrap pulse.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ctr_r  <= '0;
      wrap_r <= 1'b0;
    end else if (!running || bus.clear) begin
      ctr_r  <= '0;
      wrap_r <= 1'b0;
    end else begin
      ctr_r  <= ctr_r + one_c;
      wrap_r <= &ctr_r;
    end
  end

  assign bus.ctr     = ctr_r;
  assign bus.running = running;
  assign bus.wrap    = wrap_r;

`ifdef GATED_CYCLE_COUNTER_SNAPSHOT_EN
  logic [width_p-1:0] snap_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      snap_r <= '0;
    end else if (bus.snapshot) begin
      snap_r <= ctr_r;
    end
  end

  assign bus.snap = snap_r;
`endif

endmodule

// File: rtl/gcc_flop_chain.sv
// Single-bit flop chain with async active-low reset to 0.
// A depth of 0 degenerates to a wire.
module gcc_flop_chain #(
  parameter int depth = 2
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic d_i,
  output logic q_o
);

  if (depth == 0) begin : g_wire
    assign q_o = d_i;
  end else begin : g_chain
    logic [depth-1:0] stage;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        stage <= '0;
      end else begin
        stage[0] <= d_i;
        for (int i = 1; i < depth; i++) begin
          stage[i] <= stage[i-1];
        end
      end
    end

    assign q_o = stage[depth-1];
  end

endmodule

// File: rtl/gated_cycle_counter.sv
// Cycle counter gated by a synchronized, delayed start level.
// Define GATED_CYCLE_COUNTER_SNAPSHOT_EN for snapshot_i / snap_r_o.
module gated_cycle_counter
  import gated_cycle_counter_pkg::*;
#(
  parameter int width_p       = default_width_c,
  parameter int sync_stages_p = default_sync_c,
  parameter int delay_p       = default_delay_c
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               start_i,
  input  logic               clear_i,
  output logic [width_p-1:0] ctr_r_o,
  output logic               running_o,
  output logic               wrap_o
`ifdef GATED_CYCLE_COUNTER_SNAPSHOT_EN
  ,
  input  logic               snapshot_i,
  output logic [width_p-1:0] snap_r_o
`endif
);

  gated_cycle_counter_if #(.width_p(width_p)) bus ();

  assign bus.start = start_i;
  assign bus.clear = clear_i;
  assign ctr_r_o   = bus.ctr;
  assign running_o = bus.running;
  assign wrap_o    = bus.wrap;

`ifdef GATED_CYCLE_COUNTER_SNAPSHOT_EN
  assign bus.snapshot = snapshot_i;
  assign snap_r_o     = bus.snap;
`endif

  gated_cycle_counter_core #(
    .width_p       (width_p),
    .sync_stages_p (sync_stages_p),
    .delay_p       (delay_p)
  ) u_core (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .bus       (bus)
  );

endmodule

// File: tb/tb_gated_cycle_counter.sv
// Scoreboard bench for gated_cycle_counter: 32-bit and 4-bit instances.
// Snapshot checks compile in with GATED_CYCLE_COUNTER_SNAPSHOT_EN.
module tb_gated_cycle_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst32;
  logic rst4;

  gated_cycle_counter_if #(.width_p(32)) b32 ();
  gated_cycle_counter_if #(.width_p(4))  b4 ();

  gated_cycle_counter u_d32 (
    .clk_i      (clk),
    .reset_n_i  (rst32),
    .start_i    (b32.start),
    .clear_i    (b32.clear),
    .ctr_r_o    (b32.ctr),
    .running_o  (b32.running),
    .wrap_o     (b32.wrap)
`ifdef GATED_CYCLE_COUNTER_SNAPSHOT_EN
    ,
    .snapshot_i (b32.snapshot),
    .snap_r_o   (b32.snap)
`endif
  );

  gated_cycle_counter #(.width_p(4)) u_d4 (
    .clk_i      (clk),
    .reset_n_i  (rst4),
    .start_i    (b4.start),
    .clear_i    (b4.clear),
    .ctr_r_o    (b4.ctr),
    .running_o  (b4.running),
    .wrap_o     (b4.wrap)
`ifdef GATED_CYCLE_COUNTER_SNAPSHOT_EN
    ,
    .snapshot_i (b4.snapshot),
    .snap_r_o   (b4.snap)
`endif
  );

  typedef struct {
    int          cyc;
    int          id;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] sample(int id);
    case (id)
      0: return b32.ctr;
      1: return {31'b0, b32.running};
      2: return {31'b0, b32.wrap};
      3: return {28'b0, b4.ctr};
      4: return {31'b0, b4.running};
      5: return {31'b0, b4.wrap};
`ifdef GATED_CYCLE_COUNTER_SNAPSHOT_EN
      6: return b32.snap;
`endif
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  function automatic void want(int c, int id, logic [31:0] v, string nm);
    sb.push_back('{c, id, v, nm});
  endfunction

  task automatic until_cyc(int c);
    int guard;
    guard = 0;
    while (cyc < c && guard < 1000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    n_chk++;
    if (cyc >= c)
      n_pass++;
    else
      $display("FAIL wait_expired cyc=%0d want=%0d", cyc, c);
  endtask

  always @(negedge clk) begin
    logic [31:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        n_chk++;
        act = sample(sb[i].id);
        if (sb[i].cyc == cyc && act === sb[i].val)
          n_pass++;
        else
          $display("FAIL %s cyc=%0d due=%0d got=%0d want=%0d",
                   sb[i].name, cyc, sb[i].cyc, act, sb[i].val);
        sb.delete(i);
      end
    end
  end

  initial begin
    rst32 = 1'b0;
    rst4 = 1'b0;
    b32.start = 1'b1;
    b32.clear = 1'b0;
    b4.start = 1'b1;
    b4.clear = 1'b0;
`ifdef GATED_CYCLE_COUNTER_SNAPSHOT_EN
    b32.snapshot = 1'b0;
    b4.snapshot = 1'b0;
`endif

    for (int c = 1; c <= 16; c++) begin
      want(c, 0, 0, "rst_ctr");
      want(c, 1, 0, "rst_run");
      want(c, 2, 0, "rst_wrap");
    end
    until_cyc(8);
    n_chk++;
    if (b32.ctr === '0 && b32.running === 1'b0 &&
        b32.wrap === 1'b0 && b4.ctr === '0 &&
        b4.running === 1'b0 && b4.wrap === 1'b0)
      n_pass++;
    else
      $display("FAIL rst_direct cyc=%0d ctr=%0d run=%b",
               cyc, b32.ctr, b32.running);
    until_cyc(16);
    rst32 = 1'b1;
    b32.start = 1'b0;

    until_cyc(20);
    b32.start = 1'b1;
    want(24, 1, 0, "lat_run_lo");
    want(24, 0, 0, "lat_ctr_pre");
    want(25, 1, 1, "lat_run_hi");
    want(25, 0, 0, "cnt_0");
    want(26, 0, 1, "cnt_1");
    want(27, 0, 2, "cnt_2");

`ifdef GATED_CYCLE_COUNTER_SNAPSHOT_EN
    until_cyc(67);
    want(67, 0, 42, "snap_pre_ctr");
    b32.snapshot = 1'b1;
    want(68, 6, 42, "snap_cap");
    want(68, 0, 43, "snap_ctr_on");
    until_cyc(68);
    b32.snapshot = 1'b0;
    want(100, 6, 42, "snap_hold");
    want(100, 0, 75, "snap_ctr_75");
`endif

    until_cyc(125);
    want(125, 0, 100, "stop_at_100");
    b32.start = 1'b0;
    want(129, 1, 1, "stop_run_still");
    want(130, 0, 105, "stop_ctr_105");
    want(130, 1, 0, "stop_run_lo");
    want(131, 0, 0, "stop_ctr_zero");
    want(131, 2, 0, "stop_no_wrap");
    want(135, 0, 0, "stop_ctr_hold");

    until_cyc(140);
    b32.start = 1'b1;
    want(145, 1, 1, "rs_run_hi");
    want(145, 0, 0, "rs_ctr_0");
    want(151, 0, 6, "rs_ctr_6");
    until_cyc(152);
    #2;
    want(152, 0, 0, "async_ctr");
    want(152, 1, 0, "async_run");
    rst32 = 1'b0;

    until_cyc(155);
    rst32 = 1'b1;
    want(159, 1, 0, "rel_run_lo");
    want(159, 0, 0, "rel_ctr_0");
    want(160, 1, 1, "rel_run_hi");
    want(160, 0, 0, "rel_cnt_0");
    want(161, 0, 1, "rel_cnt_1");
    want(163, 0, 3, "rel_cnt_3");
    until_cyc(163);
    b32.start = 1'b0;

    until_cyc(170);
    rst4 = 1'b1;
    want(174, 4, 0, "w4_run_lo");
    want(175, 4, 1, "w4_run_hi");
    want(175, 3, 0, "w4_cnt_0");
    want(190, 3, 15, "w4_cnt_15");
    want(190, 5, 0, "w4_wrap_pre");
    want(191, 3, 0, "w4_wrap_ctr");
    want(191, 5, 1, "w4_wrap_pulse");
    want(192, 5, 0, "w4_wrap_end");
    want(192, 3, 1, "w4_cnt_1");

    until_cyc(206);
    want(206, 3, 15, "clr_at_15");
    b4.clear = 1'b1;
    want(207, 3, 0, "clr_ctr");
    want(207, 5, 0, "clr_no_wrap");
    until_cyc(207);
    b4.clear = 1'b0;
    want(208, 3, 1, "clr_resume");
    want(209, 5, 0, "clr_wrap_lo");

    until_cyc(212);
    if (sb.size() != 0)
      $display("FAIL sb_left n=%0d", sb.size());
    if (n_pass != n_chk)
      $display("FAIL summary %0d/%0d", n_pass, n_chk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
